// File: rtl/mul3_rr_scheduler_if.sv
// mul3_rr_scheduler_if: request and response channels of the shared 3x3 multiplier scheduler
interface mul3_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW = $clog2(NREQ)
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [3*NREQ-1:0] req_a;
  logic [3*NREQ-1:0] req_b;
  logic rsp_valid;
  logic rsp_ready;
  logic [5:0] rsp_data;
  logic [IDW-1:0] rsp_id;
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input req_ready, rsp_valid, rsp_data, rsp_id
  );
  modport slave (
    input req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/mul3_rr_scheduler.sv
// mul3_rr_scheduler: round-robin sharing of one 3x3 multiplier behind a 2-stage valid/ready pipe
module multiplier_3bit (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [5:0] p
);
  assign p = {3'b0, a} * {3'b0, b};
endmodule

module mul3_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW = $clog2(NREQ)
) (
  input logic clk,
  input logic rst,
  mul3_rr_scheduler_if.slave bus
);
  logic [IDW-1:0] ptr, grant, off, s1_id, rsp_id;
  logic [IDW:0] sum;
  logic [2*NREQ-1:0] rot;
  logic [2:0] op_a [NREQ];
  logic [2:0] op_b [NREQ];
  logic [2:0] s1_a, s1_b;
  logic [5:0] prod, rsp_data;
  logic s1_v, rsp_valid, found, adv2, free1;
  for (genvar i = 0; i < NREQ; i++) begin : g_ops
    assign op_a[i] = bus.req_a[3*i +: 3];
    assign op_b[i] = bus.req_b[3*i +: 3];
  end
  assign adv2 = !rsp_valid || bus.rsp_ready;
  assign free1 = !s1_v || adv2;
  // rotate so bit 0 is the requester at ptr; the first set bit is the offset of the grant
  assign rot = {bus.req_valid, bus.req_valid} >> ptr;
  always_comb begin
    off = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++)
      if (!found && rot[k]) begin
        found = 1'b1;
        off = IDW'(k);
      end
  end
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign grant = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
  assign bus.req_ready = (rst || !free1 || !found) ? '0 : {{(NREQ-1){1'b0}}, 1'b1} << grant;
  multiplier_3bit u_mul (.a(s1_a), .b(s1_b), .p(prod));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= '0;
      s1_v <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_id <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_id <= '0;
    end else begin
      if (free1)
        s1_v <= found;
      if (free1 && found) begin
        s1_a <= op_a[grant];
        s1_b <= op_b[grant];
        s1_id <= grant;
        ptr <= (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
      end
      if (adv2) begin
        rsp_valid <= s1_v;
        if (s1_v) begin
          rsp_data <= prod;
          rsp_id <= s1_id;
        end
      end
    end
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data = rsp_data;
  assign bus.rsp_id = rsp_id;
endmodule

// File: tb/tb_mul3_rr_scheduler.sv
// tb_mul3_rr_scheduler: vector table, hand-written corner sequences and a random scoreboard run
module tb_mul3_rr_scheduler;
  localparam int N = 4;
  typedef struct { int id; int a; int b; int exp; } vec_t;
  typedef struct { int id; int p; int stamp; } item_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  vec_t vt [6];
  item_t q [$];
  item_t it;
  int opa [N];
  int opb [N];
  int wait_cnt [N];
  logic [N-1:0] pend, acc;
  int mptr, g, j, idx;
  bit free, exp_v;
  mul3_rr_scheduler_if #(.NREQ(N)) bus ();
  mul3_rr_scheduler #(.NREQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    bus.req_a[3*i +: 3] = 3'(a);
    bus.req_b[3*i +: 3] = 3'(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    step();
    step();
    bus.req_valid = '1;
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_data", bus.rsp_data, 0);
    chk("rst_id", bus.rsp_id, 0);
    bus.req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic single(input int id, input int a, input int b, input int exp);
    bus.req_valid = '0;
    bus.req_valid[id] = 1'b1;
    set_op(id, a, b);
    bus.rsp_ready = 1'b1;
    #1;
    chk("single_ready", bus.req_ready, 1 << id);
    step();
    bus.req_valid = '0;
    set_op(id, (a + 3) % 8, (b + 5) % 8);
    chk("single_early", bus.rsp_valid, 0);
    step();
    chk("single_valid", bus.rsp_valid, 1);
    chk("single_data", bus.rsp_data, exp);
    chk("single_id", bus.rsp_id, id);
    step();
    chk("single_drain", bus.rsp_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{1, 5, 6, 30};
    vt[1] = '{0, 7, 7, 49};
    vt[2] = '{3, 0, 5, 0};
    vt[3] = '{2, 1, 1, 1};
    vt[4] = '{1, 7, 3, 21};
    vt[5] = '{3, 6, 4, 24};
    do_reset();
    // reset mid-stream: outputs drop at once, first grant afterwards is requester 0
    bus.req_valid = '1;
    for (int i = 0; i < N; i++) set_op(i, i + 1, 2);
    step();
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", bus.rsp_valid, 0);
    chk("midrst_ready", bus.req_ready, 0);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_grant0", bus.req_ready, 1);
    chk("midrst_empty", bus.rsp_valid, 0);
    step();
    do_reset();
    for (int v = 0; v < 6; v++) single(vt[v].id, vt[v].a, vt[v].b, vt[v].exp);
    for (int p = 0; p < 64; p++) single(2, p / 8, p % 8, (p / 8) * (p % 8));
    // all requesters streaming: strict rotation, one product per cycle
    do_reset();
    bus.req_valid = '1;
    for (int i = 0; i < N; i++) set_op(i, i + 1, 7);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_grant", bus.req_ready, 1 << (k % 4));
      if (k >= 2) begin
        chk("rr_valid", bus.rsp_valid, 1);
        chk("rr_data", bus.rsp_data, 7 * ((k - 2) % 4 + 1));
        chk("rr_id", bus.rsp_id, (k - 2) % 4);
      end
      step();
    end
    // backpressure with both stages full
    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0011;
    set_op(0, 2, 3);
    set_op(1, 4, 5);
    #1;
    chk("bp_ready0", bus.req_ready, 4'b0001);
    step();
    bus.req_valid = 4'b0010;
    #1;
    chk("bp_ready1", bus.req_ready, 4'b0010);
    chk("bp_nov", bus.rsp_valid, 0);
    step();
    bus.req_valid = 4'b0001;
    set_op(0, 6, 6);
    #1;
    chk("bp_full", bus.req_ready, 0);
    chk("bp_v", bus.rsp_valid, 1);
    chk("bp_d", bus.rsp_data, 6);
    chk("bp_id", bus.rsp_id, 0);
    step();
    chk("bp_full2", bus.req_ready, 0);
    chk("bp_hold_d", bus.rsp_data, 6);
    chk("bp_hold_id", bus.rsp_id, 0);
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    step();
    chk("bp_v2", bus.rsp_valid, 1);
    chk("bp_d2", bus.rsp_data, 20);
    chk("bp_id2", bus.rsp_id, 1);
    step();
    chk("bp_empty", bus.rsp_valid, 0);
    // random traffic against an in-order queue model of the two-slot pipe
    do_reset();
    mptr = 0;
    pend = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      exp_v = q.size() > 0 && q[0].stamp <= c - 2;
      chk("rnd_valid", bus.rsp_valid, exp_v);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) pend[i] = 1'b1;
        opa[i] = $urandom_range(0, 7);
        opb[i] = $urandom_range(0, 7);
        set_op(i, opa[i], opb[i]);
      end
      bus.req_valid = pend;
      bus.rsp_ready = $urandom_range(0, 3) != 0;
      #1;
      free = q.size() < 2 || bus.rsp_ready;
      g = -1;
      if (free)
        for (int k = 0; k < N; k++) begin
          j = (mptr + k) % N;
          if (g < 0 && pend[j]) g = j;
        end
      chk("rnd_ready", bus.req_ready, g < 0 ? 0 : 1 << g);
      chk("rnd_onehot", int'($countones(bus.req_ready) <= 1), 1);
      if (bus.rsp_valid && bus.rsp_ready && q.size() > 0) begin
        it = q.pop_front();
        chk("rnd_data", bus.rsp_data, it.p);
        chk("rnd_id", bus.rsp_id, it.id);
      end
      acc = bus.req_valid & bus.req_ready;
      idx = -1;
      for (int i = 0; i < N; i++) if (acc[i]) idx = i;
      if (idx >= 0) begin
        q.push_back('{idx, opa[idx] * opb[idx], c});
        chk("rnd_starve", int'(wait_cnt[idx] < N), 1);
        wait_cnt[idx] = 0;
        for (int i = 0; i < N; i++) if (pend[i] && i != idx) wait_cnt[i]++;
        pend[idx] = 1'b0;
        mptr = (idx + 1) % N;
      end
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
